// File: rtl/timestamp_counter.sv
// Microsecond timestamp with sub-us phase, software load, one-period drift trim
// and per-channel event capture with valid/ready handoff and sticky overrun.
module timestamp_counter #(
   parameter int CYCLE_NUM_1US = 125,
   parameter int TS_WIDTH      = 16,
   parameter int CAP_CH        = 2,
   localparam int SUB_W        = $clog2(CYCLE_NUM_1US + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
   input  logic                       load_valid,
   input  logic [TS_WIDTH-1:0]        load_value,
   input  logic                       trim_valid,
   input  logic                       trim_dir,
   output logic                       trim_busy,
   output logic [TS_WIDTH-1:0]        timestamp,
   output logic [SUB_W-1:0]           sub_us,
   output logic                       tick,
   output logic                       wrap,
   input  logic [CAP_CH-1:0]          cap_trig,
   output logic [CAP_CH-1:0]          cap_valid,
   input  logic [CAP_CH-1:0]          cap_ready,
   output logic [CAP_CH*TS_WIDTH-1:0] cap_ts,
   output logic [CAP_CH*SUB_W-1:0]    cap_sub,
   output logic [CAP_CH-1:0]          cap_overrun
);

   typedef enum logic [1:0] {
      TRIM_IDLE,
      TRIM_PENDING,
      TRIM_ARMED
   } trim_state_t;

   trim_state_t      trim_state;
   trim_state_t      trim_state_nxt;
   logic             trim_adv;
   logic             trim_adv_nxt;
   logic [SUB_W-1:0] term;
   logic             boundary;

   // Terminal count is only stretched or shortened for the single armed period.
   always_comb begin
      term = SUB_W'(CYCLE_NUM_1US - 1);
      if (trim_state == TRIM_ARMED) begin
         term = trim_adv ? SUB_W'(CYCLE_NUM_1US - 2) : SUB_W'(CYCLE_NUM_1US);
      end
   end

   assign boundary  = enable && (sub_us == term);
   assign trim_busy = (trim_state != TRIM_IDLE);

   always_comb begin
      trim_state_nxt = trim_state;
      trim_adv_nxt   = trim_adv;
      if (load_valid) begin
         trim_state_nxt = TRIM_IDLE;
         trim_adv_nxt   = 1'b0;
      end else begin
         case (trim_state)
            TRIM_IDLE: begin
               if (trim_valid) begin
                  trim_state_nxt = TRIM_PENDING;
                  trim_adv_nxt   = trim_dir;
               end
            end
            TRIM_PENDING: begin
               if (boundary) trim_state_nxt = TRIM_ARMED;
            end
            TRIM_ARMED: begin
               if (boundary) trim_state_nxt = TRIM_IDLE;
            end
            default: trim_state_nxt = TRIM_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trim_state <= TRIM_IDLE;
         trim_adv   <= 1'b0;
      end else begin
         trim_state <= trim_state_nxt;
         trim_adv   <= trim_adv_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timestamp <= '0;
         sub_us    <= '0;
         tick      <= 1'b0;
         wrap      <= 1'b0;
      end else begin
         tick <= 1'b0;
         wrap <= 1'b0;
         if (load_valid) begin
            timestamp <= load_value;
            sub_us    <= '0;
         end else if (boundary) begin
            timestamp <= timestamp + TS_WIDTH'(1);
            sub_us    <= '0;
            tick      <= 1'b1;
            wrap      <= &timestamp;
         end else if (enable) begin
            sub_us <= sub_us + SUB_W'(1);
         end
      end
   end

   // A slot frees up in the same cycle its held value is handed off.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_valid   <= '0;
         cap_overrun <= '0;
         cap_ts      <= '0;
         cap_sub     <= '0;
      end else begin
         for (int i = 0; i < CAP_CH; i++) begin
            if (cap_trig[i] && (!cap_valid[i] || cap_ready[i])) begin
               cap_valid[i]                    <= 1'b1;
               cap_ts[i*TS_WIDTH +: TS_WIDTH]  <= timestamp;
               cap_sub[i*SUB_W +: SUB_W]       <= sub_us;
            end else if (cap_valid[i] && cap_ready[i]) begin
               cap_valid[i] <= 1'b0;
            end

            if (cap_valid[i] && cap_ready[i]) begin
               cap_overrun[i] <= 1'b0;
            end else if (cap_trig[i] && cap_valid[i]) begin
               cap_overrun[i] <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/timestamp_counter.md
# timestamp_counter

Parametrised microsecond timestamp generator with sub-microsecond phase output, software load, single-cycle period trim for clock-drift correction, and per-channel event capture with valid/ready handoff. Sits beside the MAC/packet paths: consumers either read `timestamp`/`sub_us` live or collect latched event times from the capture channels.

## Interface

- `CYCLE_NUM_1US`, 125, clk cycles per microsecond; legal range ≥3.
- `TS_WIDTH`, 16, timestamp width in microseconds; legal range 1..64.
- `CAP_CH`, 2, number of capture channels; legal range 1..8.
- `SUB_W` (local), $clog2(CYCLE_NUM_1US+1), width of the sub-microsecond counter.

- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: high lets time advance; low freezes `sub_us` and `timestamp`.
- `load_valid` in 1: load strobe.
- `load_value` in TS_WIDTH: value loaded into `timestamp`.
- `trim_valid` in 1: trim request; accepted only when `trim_busy`=0.
- `trim_dir` in 1: 1 = advance (period one cycle shorter), 0 = retard (period one cycle longer).
- `trim_busy` out 1: trim pending or armed.
- `timestamp` out TS_WIDTH: microsecond count.
- `sub_us` out SUB_W: cycle index within the current microsecond.
- `tick` out 1: one-cycle pulse in the cycle a new `timestamp` value from increment first appears.
- `wrap` out 1: one-cycle pulse coincident with `tick` when `timestamp` goes from all-ones to 0.
- `cap_trig` in CAP_CH: per-channel capture strobe; level-sampled every cycle.
- `cap_valid` out CAP_CH: capture held.
- `cap_ready` in CAP_CH: consumer accepts the capture.
- `cap_ts` out CAP_CH*TS_WIDTH: captured timestamp; channel i is at bits [i*TS_WIDTH +: TS_WIDTH].
- `cap_sub` out CAP_CH*SUB_W: captured `sub_us`, packed the same way.
- `cap_overrun` out CAP_CH: sticky flag; set when a trigger is lost.

## Operation

- **Terminal count T:**
  - Normally CYCLE_NUM_1US-1.
  - CYCLE_NUM_1US-2 while an advance trim is armed.
  - CYCLE_NUM_1US while a retard trim is armed.
- **Counting:** when `enable`=1 and `sub_us`==T:
  - `sub_us` goes to 0 and `timestamp` increments modulo 2^TS_WIDTH.
  - `tick` is registered high; `wrap` is also high if the old `timestamp` was all-ones.
  - Otherwise `sub_us` increments.
- **Freeze:** `enable`=0 holds all counters and drives no `tick` or `wrap`. The trim state and captures keep operating.
- **Load:**
  - `load_valid`=1 sets `timestamp`=`load_value` and `sub_us`=0 and clears all trim state, independent of `enable`.
  - Load has priority over increment in the same cycle, and no `tick` or `wrap` is generated.
- **Trim state machine:** IDLE → PENDING → ARMED → IDLE.
  - IDLE → PENDING: `trim_valid` & IDLE latches `trim_dir`.
  - PENDING → ARMED: at the next increment boundary; the period starting there is the trimmed one.
  - ARMED → IDLE: at the end of the trimmed period.
  - `trim_busy` = !IDLE.
  - `trim_valid` while busy is ignored.
- **Capture, per channel i:**
  - When `cap_trig[i]`=1 and the slot is free, the current pre-update `timestamp`/`sub_us` are stored and `cap_valid[i]` rises next cycle.
  - The slot is free when `cap_valid[i]`=0, or when `cap_valid[i]` & `cap_ready[i]` in the same cycle (back-to-back accept).
  - A trigger while `cap_valid[i]` & !`cap_ready[i]` is dropped, the held data is unchanged, and `cap_overrun[i]` is set.
  - `cap_overrun[i]` clears on the next `cap_valid[i]` & `cap_ready[i]` handshake.
  - Channels are fully independent.

## Timing

- **Reset values:** all outputs 0, trim state IDLE.
- **First tick:** with `enable` held high from reset release, the first active edge gives `sub_us`=1, and edge CYCLE_NUM_1US gives `timestamp`=1, `sub_us`=0, `tick`=1.
- **Period length:** CYCLE_NUM_1US cycles nominally; CYCLE_NUM_1US-1 for an advance period, CYCLE_NUM_1US+1 for a retard period.
- **Latencies:**
  - Load: 1 cycle to outputs.
  - Capture: 1 cycle from trigger to `cap_valid`.
  - `tick`/`wrap`: coincident with the new `timestamp`.
- **Reset mid-operation:** asynchronously clears captures, overrun flags, trim state and counters immediately.

## Test plan

- **Free run:** CYCLE_NUM_1US=5, `enable`=1 → `tick` every 5 cycles; `timestamp` 0,1,2…; `sub_us` sequence 0..4.
- **Wrap:** TS_WIDTH=4, load 15 → the next tick gives `timestamp`=0 with `wrap`=1 and `tick`=1.
- **Trim:** advance then retard requests → exactly one period of 4 cycles, then one of 6 cycles; `trim_busy` spans request to end of trimmed period; a second `trim_valid` while busy has no effect.
- **Load collisions:** load 0x1234 coincident with a terminal count → `timestamp`=0x1234, `sub_us`=0, no `tick`. Load while `enable`=0 → applied.
- **Capture:** trigger at `timestamp`=7, `sub_us`=3 → `cap_ts`=7, `cap_sub`=3, `cap_valid` next cycle.
  - Second trigger with `cap_ready` low → `cap_overrun`=1, data still 7/3.
  - Trigger coincident with a handshake → new value captured and `cap_valid` stays high.
- **Async reset:** assert `rst` mid-period and mid-capture → all outputs 0 without a clock edge; counting restarts from 0 after release.
